// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming KxK convolution over a raster pixel stream.
// K-1 line buffers feed a KxK sliding window. The window is multiplied by a
// loadable signed kernel through a 3-stage pipeline: products, adder tree, output.
// Optional build macro: CONV2D_RELU_EN (clamps negative results to 0 in the output stage).
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
// A producer holds valid and data stable until that edge.
// out_valid/out_data/out_last are held while out_ready is low (stall).
// pix_ready is low in that case, so the whole pipeline freezes together.
module conv2d_stream_engine #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int ACC_W = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coef_load,
    input  logic [CW*K*K-1:0]     coef_data,
    input  logic                  start,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DW-1:0]         pix_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            dbg_state
);

    localparam int NT       = K * K;
    localparam int SW       = DW + CW + $clog2(NT);
    localparam int COL_BITS = $clog2(IMG_W);
    localparam int ROW_BITS = $clog2(IMG_H);

    generate
        if (ACC_W < SW) begin : g_acc_w_check
            $error("conv2d_stream_engine: ACC_W too narrow for exact sum");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [COL_BITS-1:0]   col_q;
    logic [ROW_BITS-1:0]   row_q;
    logic signed [CW-1:0]  coef_q [NT];
    logic [DW-1:0]         lb_q   [K-1][IMG_W];
    logic [DW-1:0]         win_q  [K][K];
    logic [DW-1:0]         win_d  [K][K];
    logic [DW-1:0]         col_vec[K];
    logic signed [SW-1:0]  prod_d [NT];
    logic signed [SW-1:0]  prod_q [NT];
    logic signed [SW-1:0]  sum_d, sum_q;
    logic [ACC_W-1:0]      res_d;
    logic                  s1_v_q, s1_last_q, s2_v_q, s2_last_q;
    logic                  out_valid_q, out_last_q;
    logic [ACC_W-1:0]      out_data_q;
    logic                  stall, accept, last_pix, win_ok;

    assign stall     = out_valid_q & ~out_ready;
    assign pix_ready = (state_q == ST_RUN) & ~stall;
    assign accept    = pix_valid & pix_ready;
    assign last_pix  = (row_q == ROW_BITS'(IMG_H - 1)) && (col_q == COL_BITS'(IMG_W - 1));
    // Row/column gating alone keeps windows from straddling a row wrap.
    assign win_ok    = (row_q >= ROW_BITS'(K - 1)) && (col_q >= COL_BITS'(K - 1));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: drain ends when the last result leaves an otherwise empty pipe
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_v_q && !s2_v_q && out_valid_q && out_ready && out_last_q)
                          state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Kernel register: writable only while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NT; t++) coef_q[t] <= '0;
        end else if (coef_load && state_q == ST_IDLE) begin
            for (int t = 0; t < NT; t++) coef_q[t] <= coef_data[t*CW +: CW];
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == COL_BITS'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == ROW_BITS'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Column entering the window: line buffers (oldest row on top) plus the new pixel
    always_comb begin
        for (int i = 0; i < K; i++) col_vec[i] = '0;
        col_vec[K-1] = pix_data;
        for (int m = 0; m < K - 1; m++) col_vec[K-2-m] = lb_q[m][col_q];
    end

    // Window after this pixel: shift left by one column, append col_vec on the right
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
            win_d[i][K-1] = col_vec[i];
        end
    end

    // Products of signed coefficient and zero-extended pixel, from the updated window
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod_d[i*K+j] = SW'(coef_q[i*K+j]) * $signed(SW'({1'b0, win_d[i][j]}));
            end
        end
    end

    // Line buffers and window advance only on an accepted pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < K - 1; m++)
                for (int c = 0; c < IMG_W; c++) lb_q[m][c] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win_q[i][j] <= '0;
        end else if (accept) begin
            lb_q[0][col_q] <= pix_data;
            for (int m = 1; m < K - 1; m++) lb_q[m][col_q] <= lb_q[m-1][col_q];
            win_q <= win_d;
        end
    end

    // Adder tree over the registered products
    always_comb begin
        sum_d = '0;
        for (int t = 0; t < NT; t++) sum_d = sum_d + prod_q[t];
    end

    // Output formatting: sign-extend, optionally clamp negatives
    always_comb begin
        res_d = ACC_W'(sum_q);
`ifdef CONV2D_RELU_EN
        if (sum_q[SW-1]) res_d = '0;
`else
`endif
    end

    // Three pipeline stages; a stall freezes all of them at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NT; t++) prod_q[t] <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            sum_q       <= '0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            if (accept) prod_q <= prod_d;
            s1_v_q      <= accept & win_ok;
            s1_last_q   <= accept & last_pix;
            if (s1_v_q) sum_q <= sum_d;
            s2_v_q      <= s1_v_q;
            s2_last_q   <= s1_v_q & s1_last_q;
            if (s2_v_q) out_data_q <= res_d;
            out_valid_q <= s2_v_q;
            out_last_q  <= s2_v_q & s2_last_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign frame_done = (state_q == ST_DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: default 32x32 K=3 instance plus a small 8x8 K=5 instance.
module tb_conv2d_stream_engine;

    localparam int W   = 32;
    localparam int H   = 32;
    localparam int KK  = 3;
    localparam int ACC = 20;
    localparam int NRES = (W - KK + 1) * (H - KK + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic              coef_load, start, pix_valid, pix_ready, out_valid, out_ready;
    logic              out_last, busy, frame_done;
    logic [8*KK*KK-1:0] coef_data;
    logic [7:0]        pix_data;
    logic [ACC-1:0]    out_data;
    logic [1:0]        dbg_state;

    logic              k5_coef_load, k5_start, k5_pix_valid, k5_pix_ready, k5_out_valid;
    logic              k5_out_ready, k5_out_last, k5_busy, k5_frame_done;
    logic [199:0]      k5_coef_data;
    logic [7:0]        k5_pix_data;
    logic [23:0]       k5_out_data;
    logic [1:0]        k5_dbg_state;

    conv2d_stream_engine #(.IMG_W(W), .IMG_H(H), .K(KK), .DW(8), .CW(8), .ACC_W(ACC)) dut (
        .clk(clk), .reset(reset), .coef_load(coef_load), .coef_data(coef_data),
        .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    conv2d_stream_engine #(.IMG_W(8), .IMG_H(8), .K(5), .DW(8), .CW(8), .ACC_W(24)) dut_k5 (
        .clk(clk), .reset(reset), .coef_load(k5_coef_load), .coef_data(k5_coef_data),
        .start(k5_start), .pix_valid(k5_pix_valid), .pix_ready(k5_pix_ready), .pix_data(k5_pix_data),
        .out_valid(k5_out_valid), .out_ready(k5_out_ready), .out_data(k5_out_data),
        .out_last(k5_out_last), .busy(k5_busy), .frame_done(k5_frame_done), .dbg_state(k5_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [ACC-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int img [H][W];
    int kern[KK*KK];

    function automatic logic [8*KK*KK-1:0] pack_kernel();
        logic [8*KK*KK-1:0] p;
        for (int t = 0; t < KK*KK; t++) p[t*8 +: 8] = 8'(kern[t]);
        return p;
    endfunction

    // Reference: direct KxK dot product over the stored image for every valid window
    function automatic void build_model();
        for (int r = KK - 1; r < H; r++) begin
            for (int c = KK - 1; c < W; c++) begin
                int s = 0;
                for (int i = 0; i < KK; i++)
                    for (int j = 0; j < KK; j++)
                        s += kern[i*KK+j] * img[r-KK+1+i][c-KK+1+j];
`ifdef CONV2D_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_q.push_back(ACC'(s));
            end
        end
    endfunction

    function automatic void push_const(input logic [ACC-1:0] v);
        for (int n = 0; n < NRES; n++) exp_q.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_kernel();
        @(negedge clk);
        coef_load = 1'b1;
        coef_data = pack_kernel();
        @(negedge clk);
        coef_load = 1'b0;
    endtask

    // Streams img through the DUT and checks against exp_q.
    // with_load: kernel load and start on the same edge.
    // inj_idx: pixel index at which coef_load(zero)+start are pulsed mid-run.
    // chk_idx: pixel index whose acceptance is timed against the first out_valid.
    task automatic run_frame(input bit rnd_in, input bit rnd_out, input bit with_load,
                             input int inj_idx, input int chk_idx);
        int n_exp, got, acc_cyc, first_cyc, idx, dbud, mbud;
        bit stalled, hs;
        logic [ACC-1:0] hold_d, e;
        logic hold_l;
        n_exp = exp_q.size();
        got = 0; acc_cyc = -1; first_cyc = -1; idx = 0; dbud = 40000; mbud = 40000;
        stalled = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (with_load) begin
            coef_load = 1'b1;
            coef_data = pack_kernel();
        end
        @(negedge clk);
        start = 1'b0;
        coef_load = 1'b0;
        fork
            begin
                while (idx < W*H && dbud > 0) begin
                    @(negedge clk);
                    dbud--;
                    pix_valid = rnd_in ? ($urandom_range(0, 1) == 1) : 1'b1;
                    pix_data  = 8'(img[idx/W][idx%W]);
                    coef_load = (idx == inj_idx);
                    start     = (idx == inj_idx);
                    if (idx == inj_idx) coef_data = '0;
                    #4;
                    hs = pix_valid & pix_ready;
                    if (hs && idx == chk_idx) acc_cyc = cyc;
                    if (hs) idx++;
                end
                @(negedge clk);
                pix_valid = 1'b0;
                coef_load = 1'b0;
                start = 1'b0;
            end
            begin
                while (got < n_exp && mbud > 0) begin
                    @(negedge clk);
                    mbud--;
                    out_ready = rnd_out ? ($urandom_range(0, 1) == 1) : 1'b1;
                    #4;
                    if (stalled) begin
                        n_cmp++;
                        if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
                            n_fail++;
                            $display("FAIL stall_hold: got v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                                     out_valid, out_data, out_last, hold_d, hold_l);
                        end
                    end
                    if (out_valid && first_cyc < 0) first_cyc = cyc;
                    if (out_valid && !out_ready) begin
                        n_cmp++;
                        if (pix_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL pix_ready_stall: got %0b required 0", pix_ready);
                        end
                        stalled = 1'b1;
                        hold_d = out_data;
                        hold_l = out_last;
                    end else begin
                        stalled = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (out_data !== e) begin
                            n_fail++;
                            $display("FAIL result[%0d]: got %0h required %0h", got, out_data, e);
                        end
                        n_cmp++;
                        if (out_last !== (got == n_exp - 1)) begin
                            n_fail++;
                            $display("FAIL out_last[%0d]: got %0b required %0b", got, out_last, got == n_exp - 1);
                        end
                        got++;
                    end
                end
                out_ready = 1'b1;
            end
        join
        n_cmp++;
        if (got != n_exp || dbud == 0) begin
            n_fail++;
            $display("FAIL frame_count: got %0d results required %0d (pixels sent %0d)", got, n_exp, idx);
            exp_q.delete();
        end else begin
            // The driver tail may have consumed cycles after the last result; only check if not past DONE.
            if (chk_idx >= 0) begin
                n_cmp++;
                if (first_cyc - acc_cyc != 3) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles required 3", first_cyc - acc_cyc);
                end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dbg_state !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL end_idle: got state=%0d busy=%0b required state=0 busy=0", dbg_state, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_last, busy, frame_done, pix_ready} !== 5'b0 || out_data !== '0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%0h l=%0b busy=%0b fd=%0b pr=%0b st=%0d required all 0",
                     out_valid, out_data, out_last, busy, frame_done, pix_ready, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Identity kernel, ramp image; also checks frame_done one cycle after the final handshake.
    task automatic test_identity();
        int fd_seen, wait_cyc;
        for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r*32 + c) & 255;
        load_kernel();
        for (int n = 0; n < NRES; n++) exp_q.push_back(ACC'(((n/30 + 1)*32 + (n%30 + 1)) & 255));
        fd_seen = 0;
        fork
            run_frame(1'b0, 1'b0, 1'b0, -1, -1);
            begin
                wait_cyc = 0;
                while (wait_cyc < 3000 && !fd_seen) begin
                    @(negedge clk);
                    #4;
                    wait_cyc++;
                    if (out_valid && out_ready && out_last) begin
                        @(negedge clk);
                        #4;
                        fd_seen = 1;
                        n_cmp++;
                        if (frame_done !== 1'b1 || busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL frame_done: got fd=%0b busy=%0b required fd=1 busy=0", frame_done, busy);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (!fd_seen) begin
            n_fail++;
            $display("FAIL frame_done_seen: got 0 required 1");
        end
    endtask

    task automatic test_all_ones();
        for (int t = 0; t < 9; t++) kern[t] = 1;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
        push_const(20'h008F7);
        run_frame(1'b0, 1'b0, 1'b1, -1, 2*W + 2);
    endtask

    task automatic test_sobel();
        int sob[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c * 4;
        for (int t = 0; t < 9; t++) kern[t] = sob[t];
        load_kernel();
        push_const(20'd32);
        run_frame(1'b0, 1'b0, 1'b0, -1, -1);
        for (int t = 0; t < 9; t++) kern[t] = -sob[t];
        load_kernel();
`ifdef CONV2D_RELU_EN
        push_const(20'h00000);
`else
        push_const(20'hFFFE0);
`endif
        run_frame(1'b0, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back_random();
        for (int t = 0; t < 9; t++) kern[t] = (t == 4) ? 1 : 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r*32 + c) & 255;
        load_kernel();
        for (int n = 0; n < NRES; n++) exp_q.push_back(ACC'(((n/30 + 1)*32 + (n%30 + 1)) & 255));
        run_frame(1'b1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_reset_midframe();
        int acc, bud;
        for (int t = 0; t < 9; t++) kern[t] = 1;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
        load_kernel();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        acc = 0; bud = 5000; out_ready = 1'b1;
        while (acc < 500 && bud > 0) begin
            @(negedge clk);
            bud--;
            pix_valid = 1'b1;
            pix_data = 8'd255;
            #4;
            if (pix_valid && pix_ready) acc++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_last, busy, frame_done, pix_ready} !== 5'b0 || out_data !== '0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got v=%0b d=%0h l=%0b busy=%0b fd=%0b pr=%0b st=%0d required all 0",
                     out_valid, out_data, out_last, busy, frame_done, pix_ready, dbg_state);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Kernel was cleared by reset: a frame without reload yields zeros.
        push_const('0);
        run_frame(1'b0, 1'b0, 1'b0, -1, -1);
        load_kernel();
        push_const(20'h008F7);
        run_frame(1'b1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_ignored_controls();
        for (int t = 0; t < 9; t++) kern[t] = 1;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 255;
        load_kernel();
        push_const(20'h008F7);
        run_frame(1'b0, 1'b0, 1'b0, 100, -1);
    endtask

    task automatic test_random_kernel();
        for (int t = 0; t < 9; t++) kern[t] = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
        load_kernel();
        build_model();
        run_frame(1'b1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_small_k5();
        int got, idx, bud;
        logic [199:0] kc;
        for (int t = 0; t < 25; t++) kc[t*8 +: 8] = 8'd1;
        @(negedge clk);
        k5_coef_load = 1'b1; k5_coef_data = kc; k5_start = 1'b1;
        @(negedge clk);
        k5_coef_load = 1'b0; k5_start = 1'b0;
        got = 0; idx = 0; bud = 2000;
        fork
            begin
                while (idx < 64 && bud > 0) begin
                    @(negedge clk);
                    bud--;
                    k5_pix_valid = 1'b1;
                    k5_pix_data = 8'd255;
                    #4;
                    if (k5_pix_valid && k5_pix_ready) idx++;
                end
                @(negedge clk);
                k5_pix_valid = 1'b0;
            end
            begin
                while (got < 16 && bud > 0) begin
                    @(negedge clk);
                    bud--;
                    #4;
                    if (k5_out_valid) begin
                        n_cmp++;
                        if (k5_out_data !== 24'd6375 || k5_out_last !== (got == 15)) begin
                            n_fail++;
                            $display("FAIL k5_result[%0d]: got %0d last=%0b required 6375 last=%0b",
                                     got, k5_out_data, k5_out_last, got == 15);
                        end
                        got++;
                    end
                end
            end
        join
        n_cmp++;
        if (got != 16) begin
            n_fail++;
            $display("FAIL k5_count: got %0d required 16", got);
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        reset = 1'b1;
        coef_load = 1'b0; coef_data = '0; start = 1'b0;
        pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        k5_coef_load = 1'b0; k5_coef_data = '0; k5_start = 1'b0;
        k5_pix_valid = 1'b0; k5_pix_data = '0; k5_out_ready = 1'b1;
        test_reset();
        test_identity();
        test_all_ones();
        test_sobel();
        test_back_to_back_random();
        test_reset_midframe();
        test_ignored_controls();
        test_random_kernel();
        test_small_k5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
